// File: rtl/gcm_block_sequencer.sv
// GCM block sequencer: expands one (AAD, text, IV) request into the ordered
// stream of block descriptors (AAD, counter blocks, length block, tag J0).
module gcm_block_sequencer #(
    parameter int unsigned MAX_BITS = 100000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_start,
    input  logic [63:0]  i_aad_len,
    input  logic [63:0]  i_txt_len,
    input  logic [95:0]  i_iv,
    input  logic         i_ready,
    output logic         o_valid,
    output logic [2:0]   o_phase,
    output logic [127:0] o_ctr_block,
    output logic [15:0]  o_blk_idx,
    output logic         o_busy,
    output logic         o_done,
    output logic         o_err
);

    localparam int unsigned BLK_W = 57;
    localparam logic [64:0] MAX_SUM = 65'(MAX_BITS);

    localparam logic [2:0] PH_IDLE  = 3'b100;
    localparam logic [2:0] PH_AAD   = 3'b010;
    localparam logic [2:0] PH_FIRST = 3'b000;
    localparam logic [2:0] PH_MID   = 3'b001;
    localparam logic [2:0] PH_LAST  = 3'b011;
    localparam logic [2:0] PH_ONLY  = 3'b111;
    localparam logic [2:0] PH_LEN   = 3'b101;
    localparam logic [2:0] PH_TAG   = 3'b110;

    typedef enum logic [2:0] {IDLE, AAD, TXT, LEN, TAG} state_t;

    state_t             state_q, state_d;
    logic [95:0]        iv_q, iv_d;
    logic [BLK_W-1:0]   aad_blk_q, aad_blk_d;
    logic [BLK_W-1:0]   txt_blk_q, txt_blk_d;
    logic [BLK_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        ctr_q, ctr_d;
    logic [15:0]        idx_q, idx_d;

    logic               valid_q, valid_d;
    logic [2:0]         phase_q, phase_d;
    logic [127:0]       ctr_block_q, ctr_block_d;
    logic [15:0]        blk_idx_q, blk_idx_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic [64:0]        len_sum;
    logic [BLK_W-1:0]   aad_blk_new, txt_blk_new;
    logic               accept;

    function automatic logic [2:0] txt_phase(input logic [BLK_W-1:0] cnt,
                                             input logic [BLK_W-1:0] nblk);
        if (nblk == BLK_W'(1))            return PH_ONLY;
        else if (cnt == '0)               return PH_FIRST;
        else if (cnt == nblk - BLK_W'(1)) return PH_LAST;
        else                              return PH_MID;
    endfunction

    // Block counts round partial blocks up; the length check uses the full 65-bit sum.
    always_comb begin
        len_sum     = {1'b0, i_aad_len} + {1'b0, i_txt_len};
        aad_blk_new = i_aad_len[63:7] + {{(BLK_W-1){1'b0}}, |i_aad_len[6:0]};
        txt_blk_new = i_txt_len[63:7] + {{(BLK_W-1){1'b0}}, |i_txt_len[6:0]};
        accept      = valid_q && i_ready;
    end

    always_comb begin
        state_d   = state_q;
        iv_d      = iv_q;
        aad_blk_d = aad_blk_q;
        txt_blk_d = txt_blk_q;
        cnt_d     = cnt_q;
        ctr_d     = ctr_q;
        idx_d     = idx_q;
        done_d    = 1'b0;
        err_d     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (i_start) begin
                    if (len_sum > MAX_SUM) begin
                        err_d = 1'b1;
                    end else begin
                        iv_d      = i_iv;
                        aad_blk_d = aad_blk_new;
                        txt_blk_d = txt_blk_new;
                        cnt_d     = '0;
                        ctr_d     = 32'd2;
                        idx_d     = '0;
                        if (aad_blk_new != '0)      state_d = AAD;
                        else if (txt_blk_new != '0) state_d = TXT;
                        else                        state_d = LEN;
                    end
                end
            end
            AAD: begin
                if (accept) begin
                    idx_d = idx_q + 16'd1;
                    cnt_d = cnt_q + BLK_W'(1);
                    if (cnt_q == aad_blk_q - BLK_W'(1)) begin
                        cnt_d   = '0;
                        state_d = (txt_blk_q != '0) ? TXT : LEN;
                    end
                end
            end
            TXT: begin
                if (accept) begin
                    idx_d = idx_q + 16'd1;
                    cnt_d = cnt_q + BLK_W'(1);
                    ctr_d = ctr_q + 32'd1;
                    if (cnt_q == txt_blk_q - BLK_W'(1)) begin
                        cnt_d   = '0;
                        state_d = LEN;
                    end
                end
            end
            LEN: begin
                if (accept) begin
                    idx_d   = idx_q + 16'd1;
                    state_d = TAG;
                end
            end
            TAG: begin
                if (accept) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are a registered view of the next state, so they hold while stalled.
        valid_d     = (state_d != IDLE);
        busy_d      = (state_d != IDLE);
        blk_idx_d   = (state_d == IDLE) ? 16'd0 : idx_d;
        phase_d     = PH_IDLE;
        ctr_block_d = '0;
        unique case (state_d)
            AAD:     phase_d = PH_AAD;
            TXT: begin
                phase_d     = txt_phase(cnt_d, txt_blk_d);
                ctr_block_d = {iv_d, ctr_d};
            end
            LEN:     phase_d = PH_LEN;
            TAG: begin
                phase_d     = PH_TAG;
                ctr_block_d = {iv_d, 32'd1};
            end
            default: phase_d = PH_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            valid_q     <= 1'b0;
            phase_q     <= PH_IDLE;
            ctr_block_q <= '0;
            blk_idx_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            phase_q     <= phase_d;
            ctr_block_q <= ctr_block_d;
            blk_idx_q   <= blk_idx_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    // Instance context is always reloaded by an accepted start before use.
    always_ff @(posedge clk) begin
        iv_q      <= iv_d;
        aad_blk_q <= aad_blk_d;
        txt_blk_q <= txt_blk_d;
        cnt_q     <= cnt_d;
        ctr_q     <= ctr_d;
        idx_q     <= idx_d;
    end

    assign o_valid     = valid_q;
    assign o_phase     = phase_q;
    assign o_ctr_block = ctr_block_q;
    assign o_blk_idx   = blk_idx_q;
    assign o_busy      = busy_q;
    assign o_done      = done_q;
    assign o_err       = err_q;

endmodule

// File: tb/tb_gcm_block_sequencer.sv
// Bench for gcm_block_sequencer: a descriptor-list model of each instance,
// checked every cycle, plus literal phase/counter sequences per scenario.
module tb_gcm_block_sequencer;

    localparam int unsigned MAXB = 100000;

    logic         clk = 1'b0;
    logic         rst;
    logic         i_start;
    logic [63:0]  i_aad_len;
    logic [63:0]  i_txt_len;
    logic [95:0]  i_iv;
    logic         i_ready;
    logic         o_valid;
    logic [2:0]   o_phase;
    logic [127:0] o_ctr_block;
    logic [15:0]  o_blk_idx;
    logic         o_busy;
    logic         o_done;
    logic         o_err;

    gcm_block_sequencer #(.MAX_BITS(MAXB)) dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_aad_len(i_aad_len),
        .i_txt_len(i_txt_len), .i_iv(i_iv), .i_ready(i_ready),
        .o_valid(o_valid), .o_phase(o_phase), .o_ctr_block(o_ctr_block),
        .o_blk_idx(o_blk_idx), .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]   ph;
        logic [127:0] cb;
        logic [15:0]  idx;
    } desc_t;

    desc_t        exp_q[$];
    logic         exp_done = 1'b0;
    logic         exp_err  = 1'b0;
    logic         chk_en   = 1'b0;
    int           checks   = 0;
    int           errors   = 0;

    logic [2:0]   obs_ph[$];
    logic [31:0]  obs_ct[$];
    int           done_cnt = 0;
    int           err_cnt  = 0;
    logic [2:0]   e_ph[$];
    logic [31:0]  e_ct[$];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h @%0t", nm, act, exp, $time);
        end
    endtask

    // Model: an accepted start expands into its full descriptor list.
    task automatic build(input logic [63:0] aad, input logic [63:0] txt, input logic [95:0] iv);
        longint na, nt;
        int k;
        desc_t d;
        na = longint'(aad / 128) + ((aad % 128) != 0 ? 1 : 0);
        nt = longint'(txt / 128) + ((txt % 128) != 0 ? 1 : 0);
        k = 0;
        for (longint a = 0; a < na; a++) begin
            d = '{ph: 3'b010, cb: '0, idx: 16'(k)}; exp_q.push_back(d); k++;
        end
        for (longint t = 0; t < nt; t++) begin
            d.ph  = (nt == 1) ? 3'b111 : (t == 0) ? 3'b000 : (t == nt - 1) ? 3'b011 : 3'b001;
            d.cb  = {iv, 32'(t + 2)};
            d.idx = 16'(k);
            exp_q.push_back(d); k++;
        end
        d = '{ph: 3'b101, cb: '0, idx: 16'(k)}; exp_q.push_back(d); k++;
        d = '{ph: 3'b110, cb: {iv, 32'd1}, idx: 16'(k)}; exp_q.push_back(d);
    endtask

    always @(posedge clk) begin
        logic [64:0] sum;
        exp_done <= 1'b0;
        exp_err  <= 1'b0;
        if (rst) begin
            exp_q.delete();
        end else if (exp_q.size() > 0) begin
            if (i_ready) begin
                void'(exp_q.pop_front());
                if (exp_q.size() == 0) exp_done <= 1'b1;
            end
        end else if (i_start) begin
            sum = {1'b0, i_aad_len} + {1'b0, i_txt_len};
            if (sum > 65'(MAXB)) exp_err <= 1'b1;
            else build(i_aad_len, i_txt_len, i_iv);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            if (exp_q.size() > 0) begin
                chk("valid", 128'(o_valid), 128'd1);
                chk("busy", 128'(o_busy), 128'd1);
                chk("phase", 128'(o_phase), 128'(exp_q[0].ph));
                chk("ctr_block", o_ctr_block, exp_q[0].cb);
                chk("blk_idx", 128'(o_blk_idx), 128'(exp_q[0].idx));
            end else begin
                chk("idle_valid", 128'(o_valid), 128'd0);
                chk("idle_busy", 128'(o_busy), 128'd0);
                chk("idle_phase", 128'(o_phase), 128'b100);
                chk("idle_ctr_block", o_ctr_block, 128'd0);
                chk("idle_blk_idx", 128'(o_blk_idx), 128'd0);
            end
            chk("done", 128'(o_done), 128'(exp_done));
            chk("err", 128'(o_err), 128'(exp_err));
            if (o_valid && i_ready) begin
                obs_ph.push_back(o_phase);
                obs_ct.push_back(o_ctr_block[31:0]);
            end
            done_cnt <= done_cnt + int'(o_done);
            err_cnt  <= err_cnt + int'(o_err);
        end
    end

    task automatic start(input logic [63:0] aad, input logic [63:0] txt, input logic [95:0] iv);
        i_start = 1'b1; i_aad_len = aad; i_txt_len = txt; i_iv = iv;
        @(posedge clk); #1;
        i_start = 1'b0;
    endtask

    task automatic wait_idle(input int maxc);
        int n = 0;
        while (exp_q.size() != 0 && n < maxc) begin
            @(negedge clk); n++;
        end
        if (exp_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL timeout actual=%0d descriptors left required=0", exp_q.size());
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
    endtask

    task automatic chk_seq(input string nm, input int base);
        chk({nm, "_count"}, 128'(obs_ph.size() - base), 128'(e_ph.size()));
        for (int i = 0; i < e_ph.size(); i++) begin
            if (base + i < obs_ph.size()) begin
                chk($sformatf("%s_ph%0d", nm, i), 128'(obs_ph[base + i]), 128'(e_ph[i]));
                chk($sformatf("%s_ct%0d", nm, i), 128'(obs_ct[base + i]), 128'(e_ct[i]));
            end
        end
    endtask

    initial begin
        int b, d0, e0;
        rst = 1'b1; i_start = 1'b0; i_aad_len = '0; i_txt_len = '0; i_iv = '0; i_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 chk_en = 1'b1;
        // reset held together with a start: reset wins
        i_start = 1'b1; i_txt_len = 64'd128;
        @(posedge clk); #1;
        i_start = 1'b0; rst = 1'b0;
        chk("rst_valid", 128'(o_valid), 128'd0);
        chk("rst_phase", 128'(o_phase), 128'b100);
        chk("rst_busy", 128'(o_busy), 128'd0);

        // aad=256, txt=384
        b = obs_ph.size(); d0 = done_cnt;
        start(64'd256, 64'd384, 96'hA1A2A3A4_B1B2B3B4_C1C2C3C4);
        wait_idle(40);
        e_ph = '{3'b010, 3'b010, 3'b000, 3'b001, 3'b011, 3'b101, 3'b110};
        e_ct = '{32'd0, 32'd0, 32'd2, 32'd3, 32'd4, 32'd0, 32'd1};
        chk_seq("s1", b);
        chk("s1_done_cnt", 128'(done_cnt - d0), 128'd1);

        // aad=0, txt=100: one partial text block
        b = obs_ph.size();
        start(64'd0, 64'd100, 96'h0123_4567_89AB_CDEF_0011_2233);
        wait_idle(20);
        e_ph = '{3'b111, 3'b101, 3'b110};
        e_ct = '{32'd2, 32'd0, 32'd1};
        chk_seq("s2", b);

        // aad=0, txt=0
        b = obs_ph.size(); d0 = done_cnt;
        start(64'd0, 64'd0, 96'h5);
        wait_idle(20);
        e_ph = '{3'b101, 3'b110};
        e_ct = '{32'd0, 32'd1};
        chk_seq("s3", b);
        chk("s3_done_cnt", 128'(done_cnt - d0), 128'd1);

        // over-length and 64-bit-wrapping sums are rejected
        b = obs_ph.size(); e0 = err_cnt;
        start(64'd50000, 64'd50001, 96'h7);
        @(posedge clk); #1;
        start(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 96'h8);
        @(posedge clk); #1;
        chk("s4_err_cnt", 128'(err_cnt - e0), 128'd2);
        chk("s4_no_valid", 128'(obs_ph.size() - b), 128'd0);

        // exact MAX_BITS boundary is accepted
        b = obs_ph.size();
        start(64'd50000, 64'd50000, 96'hFEED_FACE_CAFE_BEEF_1234_5678);
        wait_idle(900);
        chk("s5_count", 128'(obs_ph.size() - b), 128'd784);

        // stall mid-text with a start pulse during busy
        b = obs_ph.size(); d0 = done_cnt;
        start(64'd128, 64'd512, 96'h1111_2222_3333_4444_5555_6666);
        repeat (2) @(posedge clk);
        #1 i_ready = 1'b0;
        @(posedge clk); #1;
        start(64'd0, 64'd128, 96'h9);
        repeat (3) @(posedge clk);
        #1;
        chk("stall_phase", 128'(o_phase), 128'b001);
        chk("stall_ctr", o_ctr_block, {96'h1111_2222_3333_4444_5555_6666, 32'd3});
        chk("stall_idx", 128'(o_blk_idx), 128'd2);
        i_ready = 1'b1;
        wait_idle(30);
        e_ph = '{3'b010, 3'b000, 3'b001, 3'b001, 3'b011, 3'b101, 3'b110};
        e_ct = '{32'd0, 32'd2, 32'd3, 32'd4, 32'd5, 32'd0, 32'd1};
        chk_seq("s6", b);
        chk("s6_done_cnt", 128'(done_cnt - d0), 128'd1);

        // reset during text aborts, then a fresh start restarts ctr and idx
        d0 = done_cnt;
        start(64'd0, 64'd640, 96'hABCD);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_valid", 128'(o_valid), 128'd0);
        chk("abort_ctr", o_ctr_block, 128'd0);
        @(posedge clk); #1;
        chk("abort_no_done", 128'(done_cnt - d0), 128'd0);
        start(64'd0, 64'd256, 96'hBEEF);
        chk("fresh_phase", 128'(o_phase), 128'b000);
        chk("fresh_ctr", o_ctr_block, {96'hBEEF, 32'd2});
        chk("fresh_idx", 128'(o_blk_idx), 128'd0);
        wait_idle(20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
